// File: rtl/mux4_rr_arbiter_if.sv
// Handshake bundle between the four requesters and the round-robin arbiter
// that owns the shared 4:1 bit-select mux.
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] d_in;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       y;
  logic       tout;

  // Requester side
  modport master (
    output req, done, d_in,
    input  gnt, sel, busy, y, tout
  );

  // Arbiter side
  modport slave (
    input  req, done, d_in,
    output gnt, sel, busy, y, tout
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter and sequencer for the shared 4:1 bit-select mux.
// Grants one requester at a time, drives the mux select and gates the
// selected data bit onto y while a grant is active.
// Optional feature: define ARB_TIMEOUT_EN to force release of a grant held
// for TO_CYCLES cycles (pulses tout); otherwise grants are held indefinitely.
module mux4_rr_arbiter #(
  parameter int unsigned TO_CYCLES = 12,
  parameter int unsigned TO_W      = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  mux4_rr_arbiter_if.slave   io_bus
);

  typedef enum logic {StIdle, StGrant} state_e;

  // Counter must be able to reach TO_CYCLES-1
  if ((TO_CYCLES == 0) || (TO_CYCLES > (32'd1 << TO_W))) begin : g_cfg_err
    $error("mux4_rr_arbiter: TO_CYCLES must be in 1..2**TO_W");
  end

  state_e     r_state, w_state_d;
  logic [3:0] r_gnt,   w_gnt_d;
  logic [1:0] r_sel,   w_sel_d;
  logic       r_busy,  w_busy_d;
  logic [1:0] r_ptr,   w_ptr_d;

  logic [1:0] w_owner;
  logic [1:0] w_idx;
  logic       w_found;
  logic       w_release;

`ifdef ARB_TIMEOUT_EN
  logic [TO_W-1:0] r_cnt, w_cnt_d;
  logic            r_tout, w_tout_d;
  logic            w_timeout;

  assign w_timeout = (r_cnt == TO_W'(TO_CYCLES - 1));
`endif

  // Owner search: first set request at or after ptr, wrapping 3 -> 0
  always_comb begin
    w_found = 1'b0;
    w_owner = r_ptr;
    w_idx   = r_ptr;
    for (int i = 0; i < 4; i++) begin
      w_idx = r_ptr + 2'(i);
      if (!w_found && io_bus.req[w_idx]) begin
        w_found = 1'b1;
        w_owner = w_idx;
      end
    end
  end

  // Owner drops its request or signals done
  assign w_release = io_bus.done | ~io_bus.req[r_sel];

  // Next-state and registered-output decode
  always_comb begin
    w_state_d = r_state;
    w_gnt_d   = r_gnt;
    w_sel_d   = r_sel;
    w_busy_d  = r_busy;
    w_ptr_d   = r_ptr;
`ifdef ARB_TIMEOUT_EN
    w_cnt_d   = r_cnt;
    w_tout_d  = 1'b0;
`endif
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_state_d = StGrant;
          w_gnt_d   = 4'b0001 << w_owner;
          w_sel_d   = w_owner;
          w_busy_d  = 1'b1;
`ifdef ARB_TIMEOUT_EN
          w_cnt_d   = '0;
`endif
        end
      end
      StGrant: begin
`ifdef ARB_TIMEOUT_EN
        if (w_release || w_timeout) begin
          // A normal release in the same cycle wins, so no timeout pulse
          w_tout_d = ~w_release;
`else
        if (w_release) begin
`endif
          w_state_d = StIdle;
          w_gnt_d   = 4'b0000;
          w_busy_d  = 1'b0;
          w_ptr_d   = r_sel + 2'd1;
        end
`ifdef ARB_TIMEOUT_EN
        else begin
          w_cnt_d = r_cnt + 1'b1;
        end
`endif
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_gnt   <= 4'b0000;
      r_sel   <= 2'd0;
      r_busy  <= 1'b0;
      r_ptr   <= 2'd0;
`ifdef ARB_TIMEOUT_EN
      r_cnt   <= '0;
      r_tout  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_d;
      r_gnt   <= w_gnt_d;
      r_sel   <= w_sel_d;
      r_busy  <= w_busy_d;
      r_ptr   <= w_ptr_d;
`ifdef ARB_TIMEOUT_EN
      r_cnt   <= w_cnt_d;
      r_tout  <= w_tout_d;
`endif
    end
  end

  assign io_bus.gnt  = r_gnt;
  assign io_bus.sel  = r_sel;
  assign io_bus.busy = r_busy;
  assign io_bus.y    = io_bus.d_in[r_sel] & r_busy;
`ifdef ARB_TIMEOUT_EN
  assign io_bus.tout = r_tout;
`else
  assign io_bus.tout = 1'b0;
`endif

`ifndef SYNTHESIS
  a_gnt_onehot: assert property (@(posedge i_clk) disable iff (i_rst)
    r_busy |-> (r_gnt == (4'b0001 << r_sel)));
  a_gnt_idle_zero: assert property (@(posedge i_clk) disable iff (i_rst)
    !r_busy |-> (r_gnt == 4'b0000));
`endif

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: reset, round-robin order, wrap,
// data gating on y, reset mid-grant and grant hold / timeout behaviour.
module tb_mux4_rr_arbiter;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  mux4_rr_arbiter_if bus ();

  mux4_rr_arbiter #(
    .TO_CYCLES (4),
    .TO_W      (4)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_st(input string tag, input logic [3:0] gnt, input logic [1:0] sel,
                          input logic busy);
    check({tag, ".gnt"}, bus.gnt, gnt);
    check({tag, ".sel"}, {2'b00, bus.sel}, {2'b00, sel});
    check({tag, ".busy"}, {3'b000, bus.busy}, {3'b000, busy});
  endtask

  initial begin
    logic [1:0] order [5];
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    n_vec    = 0;
    n_err    = 0;
    rst      = 1'b1;
    bus.req  = 4'b0000;
    bus.done = 1'b0;
    bus.d_in = 4'b0000;
    tick();
    check_st("reset", 4'b0000, 2'd0, 1'b0);
    check("reset.tout", {3'b000, bus.tout}, 4'h0);
    check("reset.y", {3'b000, bus.y}, 4'h0);

    // 1: single request, then done releases
    rst     = 1'b0;
    bus.req = 4'b0001;
    tick();
    check_st("t1.grant", 4'b0001, 2'd0, 1'b1);
    bus.done = 1'b1;
    tick();
    check_st("t1.release", 4'b0000, 2'd0, 1'b0);
    bus.done = 1'b0;
    bus.req  = 4'b0000;
    tick();
    check_st("t1.idle", 4'b0000, 2'd0, 1'b0);
    // done while idle is ignored
    bus.done = 1'b1;
    tick();
    check_st("t1.idle_done", 4'b0000, 2'd0, 1'b0);
    bus.done = 1'b0;

    // 2: all requesting from ptr=0, done pulsed each grant
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_st($sformatf("t2.grant%0d", k), 4'b0001 << order[k], order[k], 1'b1);
      bus.done = 1'b1;
      tick();
      check_st($sformatf("t2.gap%0d", k), 4'b0000, order[k], 1'b0);
      bus.done = 1'b0;
      if (k == 4) bus.req = 4'b0010;
    end

    // 3: grant to 1 (ptr becomes 2), then req=0011 wraps to 0
    tick();
    check_st("t3.grant1", 4'b0010, 2'd1, 1'b1);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    bus.req  = 4'b0011;
    tick();
    check_st("t3.wrap", 4'b0001, 2'd0, 1'b1);
    // owner drops its request: release without done
    bus.req = 4'b0000;
    tick();
    check_st("t3.drop", 4'b0000, 2'd0, 1'b0);

    // 4: ptr=1, req=0100 -> owner 2; y gating
    bus.req = 4'b0100;
    tick();
    check_st("t4.grant2", 4'b0100, 2'd2, 1'b1);
    bus.d_in = 4'b0100;
    #1 check("t4.y_hi", {3'b000, bus.y}, 4'h1);
    bus.d_in = 4'b1011;
    #1 check("t4.y_lo", {3'b000, bus.y}, 4'h0);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    bus.req  = 4'b0000;
    bus.d_in = 4'b1111;
    #1 check("t4.y_idle", {3'b000, bus.y}, 4'h0);
    check_st("t4.idle_hold", 4'b0000, 2'd2, 1'b0);

    // 5: ptr=3, grant 3, reset mid-grant, then req=1001 -> 0
    bus.req = 4'b1000;
    tick();
    check_st("t5.grant3", 4'b1000, 2'd3, 1'b1);
    rst     = 1'b1;
    bus.req = 4'b0000;
    tick();
    check_st("t5.reset", 4'b0000, 2'd0, 1'b0);
    rst     = 1'b0;
    bus.req = 4'b1001;
    tick();
    check_st("t5.grant0", 4'b0001, 2'd0, 1'b1);
    // other requesters changing during grant have no effect
    bus.req = 4'b1111;
    tick();
    check_st("t5.others", 4'b0001, 2'd0, 1'b1);
    bus.req = 4'b0001;
    tick();
    check_st("t5.others2", 4'b0001, 2'd0, 1'b1);
    bus.req = 4'b0000;
    tick();
    check_st("t5.release", 4'b0000, 2'd0, 1'b0);

    // 6: hold without done (TO_CYCLES=4)
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    bus.req = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_st($sformatf("t6.hold%0d", k), 4'b0001, 2'd0, 1'b1);
      check($sformatf("t6.tout%0d", k), {3'b000, bus.tout}, 4'h0);
    end
`ifdef ARB_TIMEOUT_EN
    tick();
    check_st("t6.forced", 4'b0000, 2'd0, 1'b0);
    check("t6.tout_pulse", {3'b000, bus.tout}, 4'h1);
    tick();
    check_st("t6.next", 4'b0010, 2'd1, 1'b1);
    check("t6.tout_clr", {3'b000, bus.tout}, 4'h0);
`else
    for (int k = 0; k < 4; k++) begin
      tick();
      check_st($sformatf("t6.forever%0d", k), 4'b0001, 2'd0, 1'b1);
      check($sformatf("t6.tout_off%0d", k), {3'b000, bus.tout}, 4'h0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
